// File: rtl/rat_recover_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rat_recover_ctrl
// Brief    : Committed register alias table with flush-time rebuild of the
//            speculative renametable through LANES write ports per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rat_recover_ctrl #(
    parameter int NUM_LREG = 32,
    parameter int PREG_W   = 6,
    parameter int LANES    = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    commit0_valid,
    input  logic [4:0]              commit0_rd,
    input  logic [PREG_W-1:0]       commit0_prd,
    input  logic                    commit1_valid,
    input  logic [4:0]              commit1_rd,
    input  logic [PREG_W-1:0]       commit1_prd,
    output logic                    commit_ready,
    input  logic                    flush_valid,
    output logic                    rename_stall,
    output logic [LANES-1:0]        rat_wr_valid,
    output logic [LANES*5-1:0]      rat_wr_addr,
    output logic [LANES*PREG_W-1:0] rat_wr_data,
    output logic                    release0_valid,
    output logic [PREG_W-1:0]       release0_prd,
    output logic                    release1_valid,
    output logic [PREG_W-1:0]       release1_prd,
    output logic                    recover_done
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_copy  = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;
    localparam logic [4:0] c_ptr_step = 5'(LANES);
    localparam logic [4:0] c_ptr_last = 5'(NUM_LREG - LANES);

    logic [1:0]        state_q, state_d;
    logic [4:0]        ptr_q, ptr_d;
    logic [PREG_W-1:0] arch_tbl_q [NUM_LREG];
    logic [PREG_W-1:0] arch_tbl_d [NUM_LREG];
    logic              release0_valid_q, release0_valid_d;
    logic              release1_valid_q, release1_valid_d;
    logic [PREG_W-1:0] release0_prd_q, release0_prd_d;
    logic [PREG_W-1:0] release1_prd_q, release1_prd_d;

    logic w_acc0;
    logic w_acc1;
    logic w_same_rd;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= c_st_idle;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            c_st_idle: begin
                if (flush_valid) begin
                    state_d = c_st_copy;
                    ptr_d   = '0;
                end
            end
            c_st_copy: begin
                // A newer flush invalidates anything already written, so start over.
                if (flush_valid) begin
                    ptr_d = '0;
                end else if (ptr_q == c_ptr_last) begin
                    state_d = c_st_done;
                end else begin
                    ptr_d = ptr_q + c_ptr_step;
                end
            end
            c_st_done: begin
                if (flush_valid) begin
                    state_d = c_st_copy;
                    ptr_d   = '0;
                end else begin
                    state_d = c_st_idle;
                end
            end
            default: begin
                state_d = c_st_idle;
                ptr_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        commit_ready = 1'b0;
        rename_stall = 1'b1;
        recover_done = 1'b0;
        rat_wr_valid = '0;
        rat_wr_addr  = '0;
        rat_wr_data  = '0;
        case (state_q)
            c_st_idle: begin
                commit_ready = 1'b1;
                rename_stall = flush_valid;
            end
            c_st_copy: begin
                for (int i = 0; i < LANES; i++) begin
                    rat_wr_valid[i]                  = 1'b1;
                    rat_wr_addr[5*i +: 5]            = ptr_q + 5'(i);
                    rat_wr_data[PREG_W*i +: PREG_W]  = arch_tbl_q[ptr_q + 5'(i)];
                end
            end
            c_st_done: begin
                recover_done = 1'b1;
            end
            default: begin
                rename_stall = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Commit path: arch table update and displaced-preg release
    // ------------------------------------------------------------------
    assign w_acc0    = commit_ready & commit0_valid & (commit0_rd != 5'd0);
    assign w_acc1    = commit_ready & commit1_valid & (commit1_rd != 5'd0);
    assign w_same_rd = (commit0_rd == commit1_rd);

    always_comb begin
        arch_tbl_d = arch_tbl_q;
        if (w_acc0) begin
            arch_tbl_d[commit0_rd] = commit0_prd;
        end
        // Younger commit wins when both target the same logical register.
        if (w_acc1) begin
            arch_tbl_d[commit1_rd] = commit1_prd;
        end
    end

    always_comb begin
        release0_valid_d = w_acc0;
        release1_valid_d = w_acc1;
        release0_prd_d   = '0;
        release1_prd_d   = '0;
        if (w_acc0) begin
            release0_prd_d = arch_tbl_q[commit0_rd];
        end
        if (w_acc1) begin
            // commit0's preg is displaced by commit1 before ever being visible in the table.
            release1_prd_d = (w_acc0 && w_same_rd) ? commit0_prd : arch_tbl_q[commit1_rd];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_LREG; i++) begin
                arch_tbl_q[i] <= PREG_W'(i);
            end
            release0_valid_q <= 1'b0;
            release1_valid_q <= 1'b0;
            release0_prd_q   <= '0;
            release1_prd_q   <= '0;
        end else begin
            arch_tbl_q       <= arch_tbl_d;
            release0_valid_q <= release0_valid_d;
            release1_valid_q <= release1_valid_d;
            release0_prd_q   <= release0_prd_d;
            release1_prd_q   <= release1_prd_d;
        end
    end

    assign release0_valid = release0_valid_q;
    assign release0_prd   = release0_prd_q;
    assign release1_valid = release1_valid_q;
    assign release1_prd   = release1_prd_q;

endmodule
`default_nettype wire

// File: tb/tb_rat_recover_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rat_recover_ctrl
// Brief    : Self-checking bench for rat_recover_ctrl (vector table + queues).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rat_recover_ctrl;

    localparam int NUM_LREG = 32;
    localparam int PREG_W   = 6;
    localparam int LANES    = 2;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    commit0_valid, commit1_valid;
    logic [4:0]              commit0_rd, commit1_rd;
    logic [PREG_W-1:0]       commit0_prd, commit1_prd;
    logic                    commit_ready;
    logic                    flush_valid;
    logic                    rename_stall;
    logic [LANES-1:0]        rat_wr_valid;
    logic [LANES*5-1:0]      rat_wr_addr;
    logic [LANES*PREG_W-1:0] rat_wr_data;
    logic                    release0_valid, release1_valid;
    logic [PREG_W-1:0]       release0_prd, release1_prd;
    logic                    recover_done;

    rat_recover_ctrl #(.NUM_LREG(NUM_LREG), .PREG_W(PREG_W), .LANES(LANES)) dut (
        .clock(clock), .reset(reset),
        .commit0_valid(commit0_valid), .commit0_rd(commit0_rd), .commit0_prd(commit0_prd),
        .commit1_valid(commit1_valid), .commit1_rd(commit1_rd), .commit1_prd(commit1_prd),
        .commit_ready(commit_ready), .flush_valid(flush_valid), .rename_stall(rename_stall),
        .rat_wr_valid(rat_wr_valid), .rat_wr_addr(rat_wr_addr), .rat_wr_data(rat_wr_data),
        .release0_valid(release0_valid), .release0_prd(release0_prd),
        .release1_valid(release1_valid), .release1_prd(release1_prd),
        .recover_done(recover_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       r0v;
        logic [5:0] r0p;
        logic       r1v;
        logic [5:0] r1p;
    } rel_t;

    typedef struct {
        logic       c0v;
        logic [4:0] rd0;
        logic [5:0] prd0;
        logic       c1v;
        logic [4:0] rd1;
        logic [5:0] prd1;
        rel_t       exp;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [11:0] data;
    } wr_t;

    int         n_total = 0;
    int         n_pass  = 0;
    logic [5:0] exp_tbl [NUM_LREG];
    wr_t        cq [$];
    rel_t       rq [$];
    vec_t       vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mkvec(input logic c0v, input int rd0, input int prd0,
                                   input logic c1v, input int rd1, input int prd1,
                                   input logic r0v, input int r0p, input logic r1v, input int r1p);
        vec_t v;
        v.c0v = c0v; v.rd0 = 5'(rd0); v.prd0 = 6'(prd0);
        v.c1v = c1v; v.rd1 = 5'(rd1); v.prd1 = 6'(prd1);
        v.exp.r0v = r0v; v.exp.r0p = 6'(r0p);
        v.exp.r1v = r1v; v.exp.r1p = 6'(r1p);
        return v;
    endfunction

    function automatic void reset_exp_tbl();
        for (int i = 0; i < NUM_LREG; i++) exp_tbl[i] = 6'(i);
    endfunction

    function automatic void push_copy();
        wr_t w;
        cq.delete();
        for (int p = 0; p < NUM_LREG; p += 2) begin
            w.addr = {5'(p + 1), 5'(p)};
            w.data = {exp_tbl[p + 1], exp_tbl[p]};
            cq.push_back(w);
        end
    endfunction

    // Flush from IDLE and follow the whole copy; optional restart and commit side-cases.
    task automatic copy_check(input int restart_at, input bit commit_in_flush, input bit commit_in_copy);
        logic [5:0] old12;
        wr_t        w;
        bit         done;
        int         exp_done;
        old12    = exp_tbl[12];
        exp_done = (restart_at > 0) ? restart_at + 17 : 17;
        flush_valid = 1'b1;
        if (commit_in_flush) begin
            commit0_valid = 1'b1; commit0_rd = 5'd12; commit0_prd = 6'd20;
            exp_tbl[12] = 6'd20;
        end
        push_copy();
        #1;
        chk("stall_in_flush_cycle", rename_stall, 1);
        chk("ready_in_flush_cycle", commit_ready, 1);
        step();
        flush_valid = 1'b0;
        commit0_valid = 1'b0;
        if (commit_in_flush) begin
            chk("flush_commit_rel_valid", release0_valid, 1);
            chk("flush_commit_rel_prd", release0_prd, old12);
        end
        done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            #1;
            chk("stall_during_copy", rename_stall, 1);
            if (rat_wr_valid != '0) begin
                chk("wr_valid_lanes", rat_wr_valid, 2'b11);
                if (cq.size() == 0) begin
                    chk("wr_unexpected", rat_wr_valid, 0);
                end else begin
                    w = cq.pop_front();
                    chk("wr_addr", rat_wr_addr, w.addr);
                    chk("wr_data", rat_wr_data, w.data);
                end
            end
            if (recover_done) begin
                chk("done_cycle", c, exp_done);
                chk("copy_items_left", cq.size(), 0);
                done = 1'b1;
            end
            if (commit_in_copy && c == 4) chk("release_during_copy", release0_valid, 0);
            if (c == restart_at) begin
                flush_valid = 1'b1;
                push_copy();
            end
            if (commit_in_copy && c == 3) begin
                commit0_valid = 1'b1; commit0_rd = 5'd9; commit0_prd = 6'd55;
                chk("ready_during_copy", commit_ready, 0);
            end
            step();
            flush_valid   = 1'b0;
            commit0_valid = 1'b0;
        end
        chk("done_seen", done, 1);
        #1;
        chk("stall_after_done", rename_stall, 0);
        chk("ready_after_done", commit_ready, 1);
        chk("done_one_cycle", recover_done, 0);
        chk("wr_idle", rat_wr_valid, 0);
    endtask

    initial begin
        rel_t r;
        reset = 1'b1;
        flush_valid = 1'b0;
        commit0_valid = 1'b0; commit0_rd = '0; commit0_prd = '0;
        commit1_valid = 1'b0; commit1_rd = '0; commit1_prd = '0;

        vecs[0] = mkvec(1, 5, 40,  0, 0, 0,   1, 5,  0, 0);
        vecs[1] = mkvec(1, 3, 33,  1, 3, 34,  1, 3,  1, 33);
        vecs[2] = mkvec(0, 0, 0,   1, 0, 50,  0, 0,  0, 0);
        vecs[3] = mkvec(1, 5, 41,  1, 7, 42,  1, 40, 1, 7);
        vecs[4] = mkvec(1, 0, 9,   1, 3, 44,  0, 0,  1, 34);
        vecs[5] = mkvec(1, 31, 60, 0, 31, 1,  1, 31, 0, 0);
        vecs[6] = mkvec(0, 3, 5,   1, 3, 45,  0, 0,  1, 44);
        vecs[7] = mkvec(0, 0, 0,   0, 0, 0,   0, 0,  0, 0);

        step();
        step();
        chk("rst_commit_ready", commit_ready, 1);
        chk("rst_rename_stall", rename_stall, 0);
        chk("rst_wr_valid", rat_wr_valid, 0);
        chk("rst_wr_addr", rat_wr_addr, 0);
        chk("rst_wr_data", rat_wr_data, 0);
        chk("rst_rel0_valid", release0_valid, 0);
        chk("rst_rel1_valid", release1_valid, 0);
        chk("rst_done", recover_done, 0);
        reset = 1'b0;
        reset_exp_tbl();

        copy_check(-1, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            commit0_valid = vecs[i].c0v; commit0_rd = vecs[i].rd0; commit0_prd = vecs[i].prd0;
            commit1_valid = vecs[i].c1v; commit1_rd = vecs[i].rd1; commit1_prd = vecs[i].prd1;
            rq.push_back(vecs[i].exp);
            if (vecs[i].c0v && vecs[i].rd0 != 0) exp_tbl[vecs[i].rd0] = vecs[i].prd0;
            if (vecs[i].c1v && vecs[i].rd1 != 0) exp_tbl[vecs[i].rd1] = vecs[i].prd1;
            step();
            commit0_valid = 1'b0;
            commit1_valid = 1'b0;
            r = rq.pop_front();
            chk($sformatf("vec%0d_rel0_valid", i), release0_valid, r.r0v);
            if (r.r0v) chk($sformatf("vec%0d_rel0_prd", i), release0_prd, r.r0p);
            chk($sformatf("vec%0d_rel1_valid", i), release1_valid, r.r1v);
            if (r.r1v) chk($sformatf("vec%0d_rel1_prd", i), release1_prd, r.r1p);
        end

        copy_check(-1, 1'b1, 1'b0);
        copy_check(5, 1'b0, 1'b1);

        flush_valid = 1'b1;
        step();
        flush_valid = 1'b0;
        repeat (7) step();
        chk("pre_reset_wr_valid", rat_wr_valid, 2'b11);
        reset = 1'b1;
        step();
        chk("mid_reset_wr_valid", rat_wr_valid, 0);
        chk("mid_reset_stall", rename_stall, 0);
        chk("mid_reset_ready", commit_ready, 1);
        chk("mid_reset_done", recover_done, 0);
        reset = 1'b0;
        reset_exp_tbl();
        copy_check(-1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
